fifo_write_arbiter: RTL and testbench

//  Shares the single write port of one fifo instance among NUM_REQ producers.

---
 rtl/fifo_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for one fifo: bounded bursts, registered fifo write, throttled on fifo occupancy.
// Build option FIFO_ARB_WATERMARK_EN: also stall once occupancy reaches HIGH_WATER.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_DATA   = 16,
  parameter int MAX_BURST  = 4,
  parameter int HIGH_WATER = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_gnt,
  input  logic [4:0]                 i_fifo_count,
  output logic                       o_fifo_wen,
  output logic [7:0]                 o_fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0] o_owner,
  output logic                       o_state
);

  localparam int IW = $clog2(NUM_REQ);

`ifdef FIFO_ARB_WATERMARK_EN
  localparam int STALL_LEVEL = (HIGH_WATER < MAX_DATA) ? HIGH_WATER : MAX_DATA;
`else
  // HIGH_WATER has no effect in this build.
  localparam int STALL_LEVEL = MAX_DATA + 0 * HIGH_WATER;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   w_owner_nxt;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   w_rr_ptr_nxt;
  logic [3:0]      r_burst_cnt;
  logic [3:0]      w_burst_cnt_nxt;
  logic            r_fifo_wen;
  logic [7:0]      r_fifo_wdata;

  logic [5:0]         w_occ;
  logic               w_stall;
  logic [IW-1:0]      w_owner_inc;
  logic [IW-1:0]      w_search_base;
  logic [IW:0]        w_pick;
  logic               w_cont;
  logic [NUM_REQ-1:0] w_gnt;
  logic [7:0]         w_gnt_data;

  // First requester at or after base, searching upward modulo NUM_REQ; MSB = found.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                          input logic [IW-1:0]      base);
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(base) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[IW'(j)]) res = {1'b1, IW'(j)};
    end
    return res;
  endfunction

  // The in-flight write is counted, so a grant is never issued into a fifo that will be full.
  assign w_occ   = {1'b0, i_fifo_count} + {5'd0, r_fifo_wen};
  assign w_stall = (w_occ >= 6'(STALL_LEVEL));

  assign w_owner_inc   = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_search_base = (r_state == ST_BURST) ? w_owner_inc : r_rr_ptr;
  assign w_pick        = rr_pick(i_req, w_search_base);
  assign w_cont        = (r_state == ST_BURST) && i_req[r_owner] &&
                         (r_burst_cnt < 4'(MAX_BURST));

  // Handshake: producer i holds i_req[i] with stable data until it sees o_gnt[i] in the
  // same cycle; a cycle with i_req[i] && o_gnt[i] is a transfer, and the producer then
  // presents the next word or drops i_req. o_gnt is combinational, at most one bit, never without i_req.
  always_comb begin
    w_gnt           = '0;
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    if (i_rst || w_stall) begin
      w_gnt = '0;
    end else if (w_cont) begin
      w_gnt[r_owner]  = 1'b1;
      w_burst_cnt_nxt = r_burst_cnt + 4'd1;
    end else begin
      // Burst over (or idle): rotate and re-arbitrate in the same cycle, no bubble.
      if (r_state == ST_BURST) w_rr_ptr_nxt = w_owner_inc;
      if (w_pick[IW]) begin
        w_gnt[w_pick[IW-1:0]] = 1'b1;
        w_owner_nxt           = w_pick[IW-1:0];
        w_burst_cnt_nxt       = 4'd1;
        w_state_nxt           = ST_BURST;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[IW'(i)]) w_gnt_data = w_gnt_data | i_req_data[8*i +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_burst_cnt  <= '0;
      r_fifo_wen   <= 1'b0;
      r_fifo_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_fifo_wen  <= |w_gnt;
      if (|w_gnt) r_fifo_wdata <= w_gnt_data;
    end
  end

  assign o_gnt        = w_gnt;
  assign o_fifo_wen   = r_fifo_wen;
  assign o_fifo_wdata = r_fifo_wdata;
  assign o_owner      = r_owner;
  assign o_state      = (r_state == ST_BURST);

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge i_clk) $onehot0(o_gnt));
  a_gnt_req:    assert property (@(posedge i_clk) (o_gnt & ~i_req) == '0);
  a_burst_max:  assert property (@(posedge i_clk) disable iff (i_rst)
                                 r_burst_cnt <= 4'(MAX_BURST));
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: grant pattern checked per cycle, fifo writes via expected-data queue.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MAX_DATA = 16;
`ifdef FIFO_ARB_WATERMARK_EN
  localparam int WM_G = -1;
`else
  localparam int WM_G = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 i_rst;
  logic [NUM_REQ-1:0]   i_req;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_gnt;
  logic [4:0]           i_fifo_count;
  logic                 o_fifo_wen;
  logic [7:0]           o_fifo_wdata;
  logic [1:0]           o_owner;
  logic                 o_state;

  fifo_write_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_DATA(MAX_DATA), .MAX_BURST(4), .HIGH_WATER(12)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_req_data(i_req_data),
    .o_gnt(o_gnt), .i_fifo_count(i_fifo_count), .o_fifo_wen(o_fifo_wen),
    .o_fifo_wdata(o_fifo_wdata), .o_owner(o_owner), .o_state(o_state)
  );

  logic [7:0] exp_q[$];
  logic [7:0] prod_data[NUM_REQ];
  int checks   = 0;
  int failures = 0;
  int pending_g = -1;
  int step = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, step, act, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NUM_REQ; i++) i_req_data[8*i +: 8] = prod_data[i];
  endtask

  // One clock cycle: apply inputs after the edge, check the combinational grant mid-cycle.
  task automatic cycle(input logic rst, input logic [3:0] req, input logic [4:0] cnt,
                       input int exp_g);
    logic [3:0] exp_gnt;
    @(posedge clk);
    #1;
    if (pending_g >= 0) begin
      prod_data[pending_g] = prod_data[pending_g] + 8'd1;
      pending_g = -1;
      drive_data();
    end
    i_rst        = rst;
    i_req        = req;
    i_fifo_count = cnt;
    step++;
    @(negedge clk);
    exp_gnt = (exp_g < 0) ? 4'b0000 : 4'(1 << exp_g);
    check_val("gnt", {28'd0, o_gnt}, {28'd0, exp_gnt});
    if (exp_g >= 0) begin
      exp_q.push_back(prod_data[exp_g]);
      pending_g = exp_g;
    end
  endtask

  task automatic check_regs(input logic wen, input logic [1:0] owner, input logic state);
    check_val("fifo_wen", {31'd0, o_fifo_wen}, {31'd0, wen});
    check_val("owner", {30'd0, o_owner}, {30'd0, owner});
    check_val("state", {31'd0, o_state}, {31'd0, state});
  endtask

  // scoreboard monitor: every fifo write must match the next expected word
  always @(negedge clk) begin
    if (o_fifo_wen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write step=%0d got=%0h expected=none", step, o_fifo_wdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_fifo_wdata !== e) begin
          failures++;
          $display("FAIL wdata step=%0d got=%0h expected=%0h", step, o_fifo_wdata, e);
        end
      end
      checks++;
      if (!(i_fifo_count < 5'(MAX_DATA))) begin
        failures++;
        $display("FAIL write_when_full step=%0d got=%0d expected=<%0d", step, i_fifo_count, MAX_DATA);
      end
    end
  end

  initial begin
    i_rst        = 1'b1;
    i_req        = '0;
    i_fifo_count = '0;
    prod_data[0] = 8'hA0;
    prod_data[1] = 8'hB0;
    prod_data[2] = 8'h10;
    prod_data[3] = 8'hC0;
    drive_data();

    // reset with every request high
    repeat (3) cycle(1'b1, 4'hF, 5'd0, -1);
    check_regs(1'b0, 2'd0, 1'b0);
    check_val("wdata_reset", {24'd0, o_fifo_wdata}, 32'd0);

    // single producer: granted every cycle, re-granted after each 4-burst
    repeat (9) cycle(1'b0, 4'b0100, 5'd0, 2);
    check_regs(1'b1, 2'd2, 1'b1);
    cycle(1'b0, 4'b0000, 5'd0, -1);

    // all requesting from a fresh reset: 0x4, 1x4, 2x4, 3x4, then 0
    cycle(1'b1, 4'b0000, 5'd0, -1);
    for (int o = 0; o < NUM_REQ; o++) repeat (4) cycle(1'b0, 4'hF, 5'd0, o);
    cycle(1'b0, 4'hF, 5'd0, 0);
    check_regs(1'b1, 2'd3, 1'b1);

    // full throttling, in-flight write counted; owner 0 resumes its burst
    cycle(1'b0, 4'hF, 5'd14, 0);
    cycle(1'b0, 4'hF, 5'd15, -1);
    cycle(1'b0, 4'hF, 5'd16, -1);
    cycle(1'b0, 4'hF, 5'd16, -1);
    cycle(1'b0, 4'hF, 5'd15, 0);
    check_regs(1'b0, 2'd0, 1'b1);
    cycle(1'b0, 4'hF, 5'd15, -1);
    cycle(1'b0, 4'hF, 5'd16, -1);
    cycle(1'b0, 4'hF, 5'd0, 0);
    cycle(1'b0, 4'hF, 5'd0, 1);

    // watermark: occupancy 12 + in-flight write
    cycle(1'b0, 4'hF, 5'd12, WM_G);

    // mid-burst reset: owner 1 with two accepts, then one reset cycle
    cycle(1'b1, 4'b0000, 5'd0, -1);
    cycle(1'b0, 4'b0010, 5'd0, 1);
    cycle(1'b0, 4'b0010, 5'd0, 1);
    check_regs(1'b1, 2'd1, 1'b1);
    cycle(1'b1, 4'hF, 5'd0, -1);
    cycle(1'b0, 4'hF, 5'd0, 0);
    check_regs(1'b0, 2'd0, 1'b0);
    check_val("wdata_midreset", {24'd0, o_fifo_wdata}, 32'd0);

    // sparse requests: owner drops out, rotation skips idle requesters
    repeat (4) cycle(1'b0, 4'b1010, 5'd0, 1);
    repeat (4) cycle(1'b0, 4'b1010, 5'd0, 3);
    cycle(1'b0, 4'b1010, 5'd0, 1);
    cycle(1'b0, 4'b0000, 5'd0, -1);
    cycle(1'b0, 4'b0001, 5'd0, 0);
    cycle(1'b0, 4'b0000, 5'd0, -1);
    cycle(1'b0, 4'b0000, 5'd0, -1);
    check_regs(1'b0, 2'd0, 1'b0);
    check_val("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
